// File: rtl/cdb_result_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_result_buffer
//  Purpose  : Transmitter side of the common-data-bus broadcast handshake.
//             Queues completed (label, data) results from one functional
//             unit in FIFO order. While it holds a result it raises a request
//             to its CDB arbiter slot. On grant it shows the head entry to
//             the CDB mux and retires it.
//  Ports    : clk        rising-edge clock
//             nRST       asynchronous active-low reset
//             inEN       functional unit presents a completed result
//             dataIn     result data
//             labelIn    producing reservation-station tag (0 = illegal)
//             available  buffer can accept a result this cycle
//             require    request to the CDB arbiter
//             requireAC  arbiter grant
//             dataOut    head data to the CDB mux (0 when idle)
//             labelOut   head tag to the CDB mux (0 when idle)
//             count      number of occupied entries
//             err        sticky protocol-error flag
//  Options  : CDB_RESULT_BUFFER_BYPASS_EN - when the buffer is empty, a legal
//             incoming result is offered to the CDB in the same cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module cdb_result_buffer #(
  parameter int DEPTH   = 4,
  parameter int DATA_W  = 32,
  parameter int LABEL_W = 4
) (
  input  logic                     clk,
  input  logic                     nRST,
  input  logic                     inEN,
  input  logic [DATA_W-1:0]        dataIn,
  input  logic [LABEL_W-1:0]       labelIn,
  output logic                     available,
  output logic                     require,
  input  logic                     requireAC,
  output logic [DATA_W-1:0]        dataOut,
  output logic [LABEL_W-1:0]       labelOut,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_ONE   = CNT_W'(1);

  logic [DATA_W-1:0]  r_data_mem  [DEPTH];
  logic [LABEL_W-1:0] r_label_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_err;

  logic w_label_ok;
  logic w_not_empty;
  logic w_avail;
  logic w_push;
  logic w_store;
  logic w_pop;
  logic w_bypass;
  logic w_require;
  logic w_err_now;

  assign w_label_ok  = (labelIn != '0);
  assign w_not_empty = (r_count != '0);
  // Derived from registered count only, so no grant-to-available path exists.
  assign w_avail     = (r_count < c_DEPTH);
  assign w_push      = inEN && w_avail && w_label_ok;

`ifdef CDB_RESULT_BUFFER_BYPASS_EN
  // An empty buffer forwards a legal incoming result straight to the mux.
  assign w_bypass  = inEN && w_label_ok && !w_not_empty;
`else
  assign w_bypass  = 1'b0;
`endif

  assign w_require = w_not_empty || w_bypass;
  // A bypassed result that is granted immediately is broadcast, never stored.
  assign w_store   = w_push && !(w_bypass && requireAC);
  assign w_pop     = requireAC && w_not_empty;
  assign w_err_now = (inEN && !w_avail) || (inEN && !w_label_ok) ||
                     (requireAC && !w_require);

  always_ff @(posedge clk) begin
    if (w_store) begin
      r_data_mem[r_wr_ptr]  <= dataIn;
      r_label_mem[r_wr_ptr] <= labelIn;
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_store) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_store && !w_pop) begin
        r_count <= r_count + c_ONE;
      end else if (!w_store && w_pop) begin
        r_count <= r_count - c_ONE;
      end
      if (w_err_now) begin
        r_err <= 1'b1;
      end
    end
  end

  always_comb begin
    dataOut  = '0;
    labelOut = '0;
    if (w_not_empty) begin
      dataOut  = r_data_mem[r_rd_ptr];
      labelOut = r_label_mem[r_rd_ptr];
    end else if (w_bypass) begin
      dataOut  = dataIn;
      labelOut = labelIn;
    end
  end

  assign available = w_avail;
  assign require   = w_require;
  assign count     = r_count;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: doc/cdb_result_buffer.md
Name: cdb_result_buffer

Overview:
- Transmitter side of the common-data-bus broadcast handshake.
- Sits between a functional unit's result/label outputs and one CDB arbiter slot.
- Queues completed (label, data) results in FIFO order and raises a request to the arbiter. On grant it presents the head entry to the CDB mux and retires it.
- Back-pressures the functional unit through an available flag, so a result is never lost while the CDB is granted to other units.

Parameters:
- DEPTH, 4, number of result entries held; power of two, minimum 2.
- DATA_W, 32, result data width.
- LABEL_W, 4, reservation-station tag width; tag value 0 means "no producer" and is never broadcast.

Ports:
- clk  input  1  rising-edge clock.
- nRST  input  1  asynchronous active-low reset.
- inEN  input  1  functional unit presents a completed result this cycle.
- dataIn  input  DATA_W  result data.
- labelIn  input  LABEL_W  tag of the producing reservation-station entry.
- available  output  1  buffer can accept a result this cycle.
- require  output  1  request to the CDB arbiter.
- requireAC  input  1  arbiter grant; one-hot across units.
- dataOut  output  DATA_W  head data, wired to the CDB mux input.
- labelOut  output  LABEL_W  head tag, wired to the CDB mux input.
- count  output  log2(DEPTH)+1  number of occupied entries.
- err  output  1  sticky protocol-error flag.

Behaviour:
- Reset (nRST=0, asynchronous):
  - count=0, read/write pointers=0, err=0.
  - require=0, dataOut=0, labelOut=0, available=1.
  - Entry storage need not be cleared.
  - Reset mid-operation discards all queued results.
- available:
  - Equals (count < DEPTH), decoded from registered count only.
  - No combinational path from requireAC to available.
  - A full buffer therefore refuses a push even in a cycle where it pops.
- require:
  - Equals (count != 0).
  - dataOut/labelOut show the head entry while require=1; they are forced to 0 when empty, so an idle mux input is harmless.
- Push, at the clock edge when inEN=1, available=1 and labelIn!=0:
  - Write the entry at the write pointer.
  - Write pointer increments modulo DEPTH.
- Pop, at the clock edge when requireAC=1 and require=1:
  - Read pointer increments modulo DEPTH.
  - The broadcast takes effect in the same cycle the grant is sampled. The arbiter and CDB are combinational, so the value seen by reservation stations is the head shown during that cycle.
- Simultaneous push and pop: count is unchanged and both pointers advance.
  - With count=1, the new entry becomes head in the next cycle.
- Latency: a result pushed at edge N raises require from edge N (visible in cycle N+1). The minimum latency from inEN to broadcast is 1 cycle.
- Errors (err is sticky until reset; the offending operation is ignored with no state change):
  - inEN=1 while available=0 (overflow): result dropped.
  - inEN=1 with labelIn=0: result dropped.
  - requireAC=1 while require=0: grant ignored.
- Ordering: strict FIFO; results broadcast in push order.
- Pointer wrap: full and empty are distinguished by count, not by pointer equality.

Optional Feature:
- Macro: CDB_RESULT_BUFFER_BYPASS_EN.
- Defined: when count=0 and inEN=1 with a legal labelIn:
  - require is asserted combinationally in the same cycle, with dataOut=dataIn and labelOut=labelIn.
  - If requireAC=1 in that cycle, the result is broadcast and not stored; count stays 0.
  - If requireAC=0, the result is pushed normally.
  - Minimum latency becomes 0 cycles.
  - Creates a combinational path inEN->require, which the arbiter must tolerate.
- Undefined: require depends only on count; minimum latency is 1 cycle as specified above.

Test Plan:
- Reset with nRST=0 mid-stream, holding 3 entries:
  - Required: count=0, require=0, dataOut=0, labelOut=0, available=1, err=0, all asynchronously before the next clk edge.
- Single result, no bypass: push label=4'h3, data=32'h0000_00A5 at edge 1; requireAC=1 in cycle 2.
  - Required: require=1 with labelOut=3 and dataOut=A5 during cycle 2; count=0 and require=0 after edge 2.
- Fill and hold: push labels 1,2,3,4 (data 10,20,30,40) with requireAC=0.
  - Required: count=4, available=0.
  - A fifth push (label 5) is dropped and sets err=1.
  - Grants then drain 1,2,3,4 in order.
- Simultaneous push/pop at count=1 (head label 6): push label 7 with requireAC=1.
  - Required: label 6 broadcast, count stays 1, next head label 7.
- Illegal inputs:
  - inEN=1 with labelIn=0: err=1, count unchanged.
  - Fresh reset, then requireAC=1 with an empty buffer: err=1, pointers unchanged.
- With CDB_RESULT_BUFFER_BYPASS_EN defined, empty buffer: inEN=1, label=9, data=32'hDEAD_BEEF, requireAC=1 in the same cycle.
  - Required: require=1, labelOut=9, dataOut=DEADBEEF combinationally; count=0 after the edge.
